// File: rtl/pulse_stretcher_if.sv
// Pulse stretcher signal bundle: pulse input plus stretched-level outputs.
// The producer of pulses is the master; the stretcher itself is the slave.
interface pulse_stretcher_if;
    logic in;
    logic q;
    logic busy;
    logic dropped;

    modport master (
        output in,
        input  q,
        input  busy,
        input  dropped
    );

    modport slave (
        input  in,
        output q,
        output busy,
        output dropped
    );
endinterface

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle pulses into a LEN-cycle level with optional retrigger,
// a mandatory low gap between stretches, and a flag for every ignored pulse.
module pulse_stretcher #(
    parameter int unsigned LEN    = 10,
    parameter int unsigned GAP    = 2,
    parameter int unsigned RETRIG = 1,
    parameter int unsigned CW     = 8
) (
    input  logic             clk,
    input  logic             rst,
    pulse_stretcher_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_GAP
    } state_t;

    localparam logic [CW-1:0] LEN_M1 = CW'(LEN - 1);
    localparam logic [CW-1:0] GAP_M1 = CW'(GAP - 1);
    localparam logic [CW-1:0] ONE    = CW'(1);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          q_r;
    logic          busy_r;
    logic          drop_r;
    logic          q_nx;
    logic          busy_nx;
    logic          drop_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            q_r    <= 1'b0;
            busy_r <= 1'b0;
            drop_r <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            q_r    <= q_nx;
            busy_r <= busy_nx;
            drop_r <= drop_nx;
        end
    end

    // A retrigger reload wins over expiry even when the count has hit zero.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            S_IDLE: begin
                if (bus.in) begin
                    state_nx = S_HOLD;
                    cnt_nx   = LEN_M1;
                end
            end
            S_HOLD: begin
                if (bus.in && (RETRIG != 0)) begin
                    cnt_nx = LEN_M1;
                end else if (cnt != '0) begin
                    cnt_nx = cnt - ONE;
                end else if (GAP != 0) begin
                    state_nx = S_GAP;
                    cnt_nx   = GAP_M1;
                end else begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end
            end
            S_GAP: begin
                if (cnt == '0) begin
                    state_nx = S_IDLE;
                end else begin
                    cnt_nx = cnt - ONE;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_comb begin
        q_nx    = (state_nx == S_HOLD);
        busy_nx = (state_nx != S_IDLE);
        drop_nx = bus.in
                  && (((state == S_HOLD) && (RETRIG == 0))
                      || (state == S_GAP));
    end

    assign bus.q       = q_r;
    assign bus.busy    = busy_r;
    assign bus.dropped = drop_r;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: four configurations share one stimulus stream
// and are checked every cycle against an interval-based model.
module tb_pulse_stretcher;

    localparam int NC = 4;
    localparam int HN = 4096;
    localparam int LAST = 2700;

    function automatic int len_of(int i);
        case (i)
            0, 1:    return 10;
            2:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic int gap_of(int i);
        case (i)
            0, 1:    return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int rtg_of(int i);
        case (i)
            0, 2:    return 1;
            default: return 0;
        endcase
    endfunction

    logic clk;
    logic rst;
    logic drv;
    logic [NC-1:0] q_v;
    logic [NC-1:0] busy_v;
    logic [NC-1:0] drop_v;

    int tests;
    int fails;
    int n;

    logic qh [NC][HN];
    logic bh [NC][HN];
    logic dh [NC][HN];

    for (genvar g = 0; g < NC; g++) begin : gi
        pulse_stretcher_if ifc ();
        assign ifc.in    = drv;
        assign q_v[g]    = ifc.q;
        assign busy_v[g] = ifc.busy;
        assign drop_v[g] = ifc.dropped;
        pulse_stretcher #(
            .LEN(len_of(g)),
            .GAP(gap_of(g)),
            .RETRIG(rtg_of(g)),
            .CW(8)
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(ifc.slave)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int cfg, input int m,
                       input logic got, input logic exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cfg%0d sample %0d: got %b expected %b",
                     nm, cfg, m, got, exp);
        end
    endtask

    // Model: each stretch is an interval of samples (acc, hi] for q and
    // (acc, be] for busy; the next sample index is the edge number plus one.
    int acc [NC];
    int hi  [NC];
    int be  [NC];
    int da  [NC];

    initial begin
        n = 0;
        for (int i = 0; i < NC; i++) begin
            acc[i] = 0;
            hi[i]  = 0;
            be[i]  = 0;
            da[i]  = -1;
        end
        forever begin
            @(negedge clk);
            n++;
            for (int i = 0; i < NC; i++) begin
                int m;
                if (rst) begin
                    acc[i] = n;
                    hi[i]  = n;
                    be[i]  = n;
                    da[i]  = -1;
                end else if (drv) begin
                    if (n > be[i]) begin
                        acc[i] = n;
                        hi[i]  = n + len_of(i);
                        be[i]  = hi[i] + gap_of(i);
                    end else if (n <= hi[i] && rtg_of(i) != 0) begin
                        hi[i] = n + len_of(i);
                        be[i] = hi[i] + gap_of(i);
                    end else begin
                        da[i] = n + 1;
                    end
                end
                m = n + 1;
                chk("q", i, m, q_v[i], (m > acc[i]) && (m <= hi[i]));
                chk("busy", i, m, busy_v[i], (m > acc[i]) && (m <= be[i]));
                chk("dropped", i, m, drop_v[i], m == da[i]);
                if (m < HN) begin
                    qh[i][m] = q_v[i];
                    bh[i][m] = busy_v[i];
                    dh[i][m] = drop_v[i];
                end
            end
        end
    end

    function automatic logic dir_in(int e);
        if (e == 10 || e == 15 || e == 27) return 1'b1;
        if (e == 110 || e == 115 || e == 124) return 1'b1;
        if (e >= 201 && e <= 500) return 1'b1;
        if (e >= 520 && e <= 560 && (e % 2) == 0) return 1'b1;
        if (e == 600 || e == 610) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run_to(input int last);
        while (n < last) begin
            @(negedge clk);
            #1;
            drv = dir_in(n + 1);
        end
    endtask

    task automatic lit(input int cfg, input int kind, input int m,
                       input logic exp);
        case (kind)
            0:       chk("lit_q", cfg, m, qh[cfg][m], exp);
            1:       chk("lit_busy", cfg, m, bh[cfg][m], exp);
            default: chk("lit_dropped", cfg, m, dh[cfg][m], exp);
        endcase
    endtask

    initial begin
        int dens;
        tests = 0;
        fails = 0;
        rst = 1'b1;
        drv = 1'b0;
        #1;
        for (int i = 0; i < NC; i++) begin
            chk("rst_q", i, 0, q_v[i], 1'b0);
            chk("rst_busy", i, 0, busy_v[i], 1'b0);
            chk("rst_dropped", i, 0, drop_v[i], 1'b0);
        end
        #2;
        rst = 1'b0;

        run_to(604);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        for (int i = 0; i < NC; i++) begin
            chk("async_q", i, n, q_v[i], 1'b0);
            chk("async_busy", i, n, busy_v[i], 1'b0);
            chk("async_dropped", i, n, drop_v[i], 1'b0);
        end
        @(negedge clk);
        #1;
        drv = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        run_to(650);

        dens = 25;
        while (n < LAST) begin
            @(negedge clk);
            #1;
            if ((n % 64) == 0) begin
                case ($urandom_range(0, 3))
                    0:       dens = 3;
                    1:       dens = 25;
                    2:       dens = 60;
                    default: dens = 100;
                endcase
            end
            drv = ($urandom_range(0, 99) < dens);
            if ($urandom_range(0, 299) == 0) begin
                #2;
                rst = 1'b1;
                @(negedge clk);
                #2;
                rst = 1'b0;
                drv = ($urandom_range(0, 99) < dens);
            end
        end

        lit(0, 0, 11, 1'b1);
        lit(0, 0, 25, 1'b1);
        lit(0, 0, 26, 1'b0);
        lit(0, 1, 27, 1'b1);
        lit(0, 1, 28, 1'b0);
        lit(0, 2, 27, 1'b0);
        lit(0, 2, 28, 1'b1);
        lit(0, 2, 29, 1'b0);
        lit(1, 0, 20, 1'b1);
        lit(1, 0, 21, 1'b0);
        lit(1, 1, 22, 1'b1);
        lit(1, 1, 23, 1'b0);
        lit(1, 2, 16, 1'b1);
        lit(1, 0, 27, 1'b0);
        lit(1, 0, 28, 1'b1);
        lit(1, 2, 116, 1'b1);
        lit(1, 0, 125, 1'b1);
        lit(1, 0, 134, 1'b1);
        lit(1, 0, 135, 1'b0);
        lit(1, 0, 211, 1'b1);
        lit(1, 0, 212, 1'b0);
        lit(1, 0, 214, 1'b0);
        lit(1, 0, 215, 1'b1);
        lit(1, 1, 214, 1'b0);
        lit(1, 2, 203, 1'b1);
        lit(1, 2, 214, 1'b1);
        lit(1, 2, 215, 1'b0);
        lit(2, 0, 300, 1'b1);
        lit(2, 0, 501, 1'b1);
        lit(2, 0, 502, 1'b0);
        lit(2, 2, 300, 1'b0);
        lit(2, 0, 523, 1'b1);
        lit(2, 0, 524, 1'b0);
        lit(2, 0, 525, 1'b1);
        lit(3, 0, 204, 1'b1);
        lit(3, 0, 205, 1'b0);
        lit(3, 0, 206, 1'b1);
        lit(3, 2, 205, 1'b1);
        lit(3, 2, 206, 1'b0);
        lit(0, 0, 607, 1'b0);
        lit(0, 0, 611, 1'b1);
        lit(0, 0, 620, 1'b1);
        lit(0, 0, 621, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
